wb_keypad_scan: RTL and testbench

Parametrised Wishbone matrix-keypad controller for the LM32 SoC. It drives one-hot row strobes and samples synchronised column inputs. Each press is debounced over whole scan frames, and one keycode per press is queued in a FIFO that the CPU pops over Wishbone. An optional level interrupt signals pending keys.

---
 rtl/wb_keypad_scan_if.sv | 21 ++
 rtl/wb_keypad_scan.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_wb_keypad_scan.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_keypad_scan_if.sv
// rtl/wb_keypad_scan_if.sv - Wishbone slave signal bundle for the keypad scanner
interface wb_keypad_scan_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_keypad_scan.sv
// rtl/wb_keypad_scan.sv - Wishbone matrix keypad scanner with frame debounce and keycode FIFO
module wb_keypad_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 3,
  parameter int SCAN_DIV   = 1024,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ROWS-1:0] row_o,
  input  logic [COLS-1:0] col_i,
  output logic            irq_o,
  wb_keypad_scan_if.slave wb
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(ROWS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROWS-1:0]  ROW_ONE   = ROWS'(1);
  localparam logic [3:0]       DB        = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_CNT,
    S_HELD,
    S_REL_CNT
  } state_t;

  logic [COLS-1:0]  col_s1;
  logic [COLS-1:0]  col_s2;
  logic             scan_en;
  logic             irq_en;
  logic [DIV_W-1:0] div_cnt;
  logic [ROW_W-1:0] row_idx;
  logic             dwell_end;
  logic             frame_end;
  logic             samp_hit;
  logic [7:0]       samp_code;
  logic             acc_hit;
  logic [7:0]       acc_code;
  logic             frame_hit;
  logic [7:0]       frame_code;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cand;
  logic [7:0]       cand_nxt;
  logic [3:0]       db_cnt;
  logic [3:0]       db_cnt_nxt;
  logic             push;
  logic [7:0]       push_code;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             ovf;
  logic             not_empty;
  logic             full;
  logic             push_ok;

  logic             ack_q;
  logic [31:0]      dat_q;
  logic             acc;
  logic             wr_acc;
  logic             rd_acc;
  logic [1:0]       reg_sel;
  logic             do_pop;
  logic             flush;
  logic             ovf_clr;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      col_s1 <= col_i;
      col_s2 <= col_s1;
    end
  end

  assign dwell_end = (div_cnt == DIV_LAST);
  assign frame_end = scan_en && dwell_end && (row_idx == ROW_LAST);
  assign row_o     = scan_en ? (ROW_ONE << row_idx) : '0;

  // Lowest pressed column of the active row; rows arrive in ascending order
  always_comb begin
    samp_hit  = 1'b0;
    samp_code = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_s2[c]) begin
        samp_hit  = 1'b1;
        samp_code = 8'(row_idx) * 8'(COLS) + 8'(c);
      end
    end
  end

  assign frame_hit  = acc_hit | samp_hit;
  assign frame_code = acc_hit ? acc_code : samp_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      row_idx  <= '0;
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (!scan_en) begin
      div_cnt  <= '0;
      row_idx  <= '0;
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (dwell_end) begin
      div_cnt <= '0;
      if (row_idx == ROW_LAST) begin
        row_idx  <= '0;
        acc_hit  <= 1'b0;
        acc_code <= '0;
      end else begin
        row_idx <= row_idx + ROW_W'(1);
        if (!acc_hit && samp_hit) begin
          acc_hit  <= 1'b1;
          acc_code <= samp_code;
        end
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_RELEASED;
      cand   <= '0;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cand   <= cand_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    db_cnt_nxt = db_cnt;
    push       = 1'b0;
    push_code  = cand;
    if (!scan_en) begin
      state_nxt  = S_RELEASED;
      db_cnt_nxt = '0;
    end else if (frame_end) begin
      case (state)
        S_RELEASED: begin
          if (frame_hit) begin
            cand_nxt   = frame_code;
            db_cnt_nxt = 4'd1;
            if (DB == 4'd1) begin
              push      = 1'b1;
              push_code = frame_code;
              state_nxt = S_HELD;
            end else begin
              state_nxt = S_PRESS_CNT;
            end
          end
        end
        S_PRESS_CNT: begin
          if (!frame_hit) begin
            state_nxt  = S_RELEASED;
            db_cnt_nxt = '0;
          end else if (frame_code == cand) begin
            db_cnt_nxt = db_cnt + 4'd1;
            if (db_cnt_nxt == DB) begin
              push      = 1'b1;
              state_nxt = S_HELD;
            end
          end else begin
            cand_nxt   = frame_code;
            db_cnt_nxt = 4'd1;
          end
        end
        S_HELD: begin
          // A different key while held is deliberately ignored (no rollover)
          if (!frame_hit) begin
            db_cnt_nxt = 4'd1;
            state_nxt  = (DB == 4'd1) ? S_RELEASED : S_REL_CNT;
          end
        end
        S_REL_CNT: begin
          if (frame_hit) begin
            state_nxt = S_HELD;
          end else begin
            db_cnt_nxt = db_cnt + 4'd1;
            if (db_cnt_nxt == DB) begin
              state_nxt = S_RELEASED;
            end
          end
        end
        default: state_nxt = S_RELEASED;
      endcase
    end
  end

  assign acc     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wr_acc  = acc & wb.wb_we_i;
  assign rd_acc  = acc & ~wb.wb_we_i;
  assign reg_sel = wb.wb_adr_i[3:2];
  assign do_pop  = rd_acc && (reg_sel == 2'd1) && not_empty;
  assign flush   = wr_acc && (reg_sel == 2'd2) && wb.wb_dat_i[2];
  assign ovf_clr = wr_acc && (reg_sel == 2'd0) && wb.wb_dat_i[2];

  assign not_empty = (fifo_cnt != '0);
  assign full      = (fifo_cnt == FIFO_FULL);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign push_ok   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !do_pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (!push_ok && do_pop) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
      if (push && !push_ok) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = {18'd0, 6'(fifo_cnt), 5'd0, ovf, full, not_empty};
      2'd1: rdata = not_empty ? {1'b1, 23'd0, mem[rd_ptr]} : 32'd0;
      2'd2: rdata = {29'd0, 1'b0, irq_en, scan_en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      scan_en <= 1'b1;
      irq_en  <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      ack_q <= acc;
      dat_q <= rd_acc ? rdata : 32'd0;
      if (wr_acc && (reg_sel == 2'd2)) begin
        scan_en <= wb.wb_dat_i[0];
        irq_en  <= wb.wb_dat_i[1];
      end
      irq_o <= irq_en & not_empty;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_keypad_scan.sv
// tb/tb_wb_keypad_scan.sv - scoreboard bench for wb_keypad_scan
module tb_wb_keypad_scan;
  localparam int ROWS       = 4;
  localparam int COLS       = 3;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME      = ROWS * SCAN_DIV;
  localparam int NKEYS      = ROWS * COLS;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ROWS-1:0]  row_o;
  logic [COLS-1:0]  col_i;
  logic             irq_o;
  logic [NKEYS-1:0] keys = '0;
  int               checks = 0;
  int               errors = 0;
  int               cyc;
  logic [7:0]       exp_q [$];
  logic             exp_ovf = 1'b0;

  wb_keypad_scan_if wb ();

  wb_keypad_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_o(row_o),
    .col_i(col_i),
    .irq_o(irq_o),
    .wb(wb)
  );

  always #5 clk = ~clk;

  // Scan phase model: cycle count since reset, frame starts when cyc % FRAME == 0
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always_comb begin
    col_i = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (row_o[r] && keys[r*COLS+c]) col_i[c] = 1'b1;
  end

  function automatic logic [NKEYS-1:0] kbit(input int code);
    logic [NKEYS-1:0] one;
    one = NKEYS'(1);
    return one << code;
  endfunction

  function automatic logic [31:0] exp_status();
    return {18'd0, 6'(exp_q.size()), 5'd0, exp_ovf,
            exp_q.size() == FIFO_DEPTH, exp_q.size() != 0};
  endfunction

  function automatic logic [31:0] exp_data_pop();
    if (exp_q.size() == 0) return 32'd0;
    return {1'b1, 23'd0, exp_q.pop_front()};
  endfunction

  task automatic model_push(input int code);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(8'(code));
    else exp_ovf = 1'b1;
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] rd);
    int lat;
    lat = 0;
    rd  = '0;
    wb.wb_adr_i = {28'd0, a, 2'b00};
    wb.wb_dat_i = d;
    wb.wb_we_i  = we;
    wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o) begin
        lat = i;
        rd  = wb.wb_dat_o;
      end
    end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL wb_ack_latency adr=%0d: got %0d cycles, required 1", a, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic align();
    for (int i = 0; i < FRAME && (cyc % FRAME) != 0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frames(input logic [NKEYS-1:0] k, input int n);
    align();
    keys = k;
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic press(input int code);
    run_frames(kbit(code), DEBOUNCE);
    model_push(code);
    run_frames('0, DEBOUNCE);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (row_o !== 4'b0001 || irq_o !== 1'b0 || wb.wb_ack_o !== 1'b0 || wb.wb_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: row=%b irq=%b ack=%b dat=%h, required 0001 0 0 0",
               row_o, irq_o, wb.wb_ack_o, wb.wb_dat_o);
    end
    reset = 1'b0;
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: got %h, required 00000000", rd);
    end
    wb_xfer(1'b0, 2'd2, 32'd0, rd);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL reset_ctrl: got %h, required 00000001", rd);
    end
    wb_xfer(1'b0, 2'd3, 32'd0, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL reg3_read: got %h, required 00000000", rd);
    end
  endtask

  task automatic test_scan();
    logic [ROWS-1:0] exp_row;
    align();
    for (int i = 0; i < FRAME + SCAN_DIV; i++) begin
      exp_row = ROWS'(1) << ((cyc / SCAN_DIV) % ROWS);
      checks++;
      if (row_o !== exp_row) begin
        errors++;
        $display("FAIL scan_row cyc=%0d: got %b, required %b", cyc, row_o, exp_row);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_press();
    logic [31:0] rd;
    logic [31:0] exp;
    run_frames(kbit(7), 5);
    model_push(7);
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL single_status: got %h, required %h", rd, exp);
    end
    exp = exp_data_pop();
    wb_xfer(1'b0, 2'd1, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL single_data: got %h, required %h", rd, exp);
    end
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL single_status_after: got %h, required %h", rd, exp);
    end
    run_frames('0, DEBOUNCE);
  endtask

  task automatic test_bounce();
    logic [31:0] rd;
    logic [31:0] exp;
    run_frames(kbit(0), 2);
    run_frames('0, 1);
    run_frames(kbit(0), 2);
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL bounce_early: got %h, required %h", rd, exp);
    end
    model_push(0);
    run_frames(kbit(0), 1);
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL bounce_status: got %h, required %h", rd, exp);
    end
    exp = exp_data_pop();
    wb_xfer(1'b0, 2'd1, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL bounce_data: got %h, required %h", rd, exp);
    end
    run_frames('0, DEBOUNCE);
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [31:0] exp;
    for (int code = 1; code <= 6; code++) press(code);
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL ovf_status: got %h, required %h", rd, exp);
    end
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      exp = exp_data_pop();
      wb_xfer(1'b0, 2'd1, 32'd0, rd);
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL ovf_data[%0d]: got %h, required %h", i, rd, exp);
      end
    end
    wb_xfer(1'b1, 2'd0, 32'h4, rd);
    exp_ovf = 1'b0;
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL ovf_clear: got %h, required %h", rd, exp);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    logic [31:0] exp;
    int          lat;
    wb_xfer(1'b1, 2'd2, 32'h3, rd);
    run_frames(kbit(11), DEBOUNCE);
    model_push(11);
    lat = 0;
    for (int i = 1; i <= 2 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (irq_o) lat = i;
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL irq_rise: irq=%b after 2 cycles, required 1", irq_o);
    end
    exp = exp_data_pop();
    wb.wb_adr_i = 32'h4;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    checks++;
    if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== exp || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_pop_ack: ack=%b dat=%h irq=%b, required 1 %h 1",
               wb.wb_ack_o, wb.wb_dat_o, irq_o, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (irq_o !== 1'b0 || wb.wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_fall: irq=%b ack=%b, required 0 0", irq_o, wb.wb_ack_o);
    end
    wb_xfer(1'b1, 2'd2, 32'h1, rd);
    run_frames('0, DEBOUNCE);
  endtask

  task automatic test_multi_key();
    logic [31:0] rd;
    logic [31:0] exp;
    run_frames(kbit(5) | kbit(9), DEBOUNCE);
    model_push(5);
    run_frames(kbit(9), 4);
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL multi_held: got %h, required %h", rd, exp);
    end
    run_frames('0, DEBOUNCE);
    run_frames(kbit(9), DEBOUNCE);
    model_push(9);
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL multi_repress: got %h, required %h", rd, exp);
    end
    for (int i = 0; i < 2; i++) begin
      exp = exp_data_pop();
      wb_xfer(1'b0, 2'd1, 32'd0, rd);
      checks++;
      if (rd !== exp) begin
        errors++;
        $display("FAIL multi_data[%0d]: got %h, required %h", i, rd, exp);
      end
    end
    run_frames('0, DEBOUNCE);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [31:0] exp;
    press(2);
    run_frames(kbit(4), 2);
    wb.wb_adr_i = 32'h4;
    wb.wb_we_i  = 1'b0;
    wb.wb_sel_i = 4'hF;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wb.wb_ack_o !== 1'b0 || row_o !== 4'b0001) begin
        errors++;
        $display("FAIL reset_mid[%0d]: ack=%b row=%b, required 0 0001", i, wb.wb_ack_o, row_o);
      end
    end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL reset_mid_fifo: got %h, required %h", rd, exp);
    end
    run_frames(kbit(4), 1);
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL reset_mid_early: got %h, required %h", rd, exp);
    end
    model_push(4);
    run_frames(kbit(4), 1);
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL reset_mid_press: got %h, required %h", rd, exp);
    end
    wb.wb_adr_i = 32'h0;
    wb.wb_we_i  = 1'b0;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (wb.wb_ack_o !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_ack[%0d]: got %b, required %b", i, wb.wb_ack_o, (i % 2) == 0);
      end
    end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp = exp_data_pop();
    wb_xfer(1'b0, 2'd1, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL reset_mid_data: got %h, required %h", rd, exp);
    end
    run_frames('0, DEBOUNCE);
  endtask

  task automatic test_scan_disable();
    logic [31:0] rd;
    logic [31:0] exp;
    press(8);
    wb_xfer(1'b1, 2'd2, 32'h0, rd);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (row_o !== 4'b0000) begin
        errors++;
        $display("FAIL disable_row[%0d]: got %b, required 0000", i, row_o);
      end
      @(posedge clk); #1;
    end
    exp = exp_status();
    wb_xfer(1'b0, 2'd0, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL disable_retain: got %h, required %h", rd, exp);
    end
    wb_xfer(1'b1, 2'd2, 32'h1, rd);
    checks++;
    if (row_o !== 4'b0001) begin
      errors++;
      $display("FAIL enable_row: got %b, required 0001", row_o);
    end
    exp = exp_data_pop();
    wb_xfer(1'b0, 2'd1, 32'd0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL disable_data: got %h, required %h", rd, exp);
    end
  endtask

  initial begin
    wb.wb_adr_i = '0;
    wb.wb_dat_i = '0;
    wb.wb_sel_i = '0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    test_reset();
    test_scan();
    test_single_press();
    test_bounce();
    test_overflow();
    test_irq();
    test_multi_key();
    test_reset_mid();
    test_scan_disable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
